// File: rtl/cga_intr_level_sched.sv
// cga_intr_level_sched
// Program-level interrupt scheduler for the CGA interrupt path.
// Sixteen active-low level requests are gathered into the sticky pending
// register PID and masked by PIE. The highest pending level above the current
// program level PIL is offered to microcode over an IRQN/INTACK handshake.
// The active-level register PIA records in-service levels, so LVLDONE can
// return to the level that was interrupted.
//
// Optional feature: define CGA_INTR_SCHED_WATCHDOG_EN to build an
// acknowledge watchdog. When it times out, the offer is withdrawn and the
// sticky TMO flag is set. Without the macro, REQ waits for INTACK with no
// limit and TMO is tied low. ACK_TIMEOUT exists only in the watchdog build.

module cga_intr_level_sched
`ifdef CGA_INTR_SCHED_WATCHDOG_EN
#(
    parameter int ACK_TIMEOUT = 255
)
`endif
(
    input  logic        MCLK,
    input  logic        RESET,
    input  logic [15:0] IREQ_15_0_N,
    input  logic [15:0] PIE_15_0,
    input  logic [15:0] FIDBO_15_0,
    input  logic        SETPID,
    input  logic        CLRPID,
    input  logic        INTACK,
    input  logic        LVLDONE,
    output logic        IRQN,
    output logic [3:0]  PVL_3_0,
    output logic [3:0]  PIL_3_0,
    output logic [15:0] PID_15_0,
    output logic [15:0] PIA_15_0,
    output logic        BUSY,
    output logic        TMO
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] pid;
    logic [15:0] pid_next;
    logic [15:0] pia;
    logic [15:0] pia_next;
    logic [15:0] pia_after_done;
    logic [3:0]  pil;
    logic [3:0]  pil_next;
    logic [3:0]  pvl;
    logic        irqn;
    logic        irqn_next;

    logic [15:0] qualified;
    logic [3:0]  cand;
    logic        cand_valid;
    logic        accept;
    logic        load_pvl;
    logic        timeout;

    // Index of the highest set bit; zero when nothing is set
    function automatic logic [3:0] top_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Candidate: highest enabled pending level. Only levels above PIL count,
    // so level 0 can never be offered.
    always_comb begin
        qualified  = pid & PIE_15_0;
        cand       = top_index(qualified);
        cand_valid = (qualified != 16'h0000) && (cand > pil);
    end

`ifdef CGA_INTR_SCHED_WATCHDOG_EN
    logic [7:0] wait_count;
    logic       tmo;

    // Timeout fires on the REQ cycle that would be the ACK_TIMEOUT-th without an acknowledge
    always_comb begin
        timeout = (state == REQ) && !INTACK && cand_valid &&
                  (wait_count == 8'(ACK_TIMEOUT - 1));
    end

    // Watchdog counter restarts on each fresh offer; TMO is sticky until reset
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            wait_count <= 8'd0;
            tmo        <= 1'b0;
        end else begin
            if (state == IDLE && state_next == REQ) begin
                wait_count <= 8'd0;
            end else if (state == REQ && !INTACK && state_next == REQ) begin
                wait_count <= wait_count + 8'd1;
            end
            if (timeout) begin
                tmo <= 1'b1;
            end
        end
    end

    assign TMO = tmo;
`else
    assign timeout = 1'b0;
    assign TMO     = 1'b0;
`endif

    // State register
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the offer handshake
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cand_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (INTACK) begin
                    state_next = SETTLE;
                end else if (!cand_valid || timeout) begin
                    state_next = IDLE;
                end
            end
            SETTLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake controls. IRQN is registered and goes low only once REQ is
    // held, so it trails the PVL latch by one edge. Leaving REQ raises it
    // again at once.
    always_comb begin
        accept    = (state == REQ) && INTACK;
        load_pvl  = ((state == IDLE) && cand_valid) ||
                    ((state == REQ) && !INTACK && cand_valid && !timeout);
        irqn_next = !((state == REQ) && (state_next == REQ));
        BUSY      = (state != IDLE);
    end

    // Pending update, in order: accepted bit, software clear, software set,
    // live requests. Later terms win on a shared bit.
    always_comb begin
        pid_next = pid;
        if (accept) begin
            pid_next[pvl] = 1'b0;
        end
        if (CLRPID) begin
            pid_next = pid_next & ~FIDBO_15_0;
        end
        if (SETPID) begin
            pid_next = pid_next | FIDBO_15_0;
        end
        pid_next = pid_next | ~IREQ_15_0_N;
    end

    // Active-level tracking. LVLDONE retires the old PIL first, and then an
    // acknowledge makes the offered level current. Bit 0 is permanently active.
    always_comb begin
        pia_after_done = pia;
        pil_next       = pil;
        if (LVLDONE && (pil != 4'd0)) begin
            pia_after_done[pil] = 1'b0;
            pil_next            = top_index(pia_after_done);
        end
        pia_next = pia_after_done;
        if (accept) begin
            pia_next[pvl] = 1'b1;
            pil_next      = pvl;
        end
        pia_next[0] = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            pid  <= 16'h0000;
            pia  <= 16'h0001;
            pil  <= 4'd0;
            pvl  <= 4'd0;
            irqn <= 1'b1;
        end else begin
            pid  <= pid_next;
            pia  <= pia_next;
            pil  <= pil_next;
            irqn <= irqn_next;
            if (load_pvl) begin
                pvl <= cand;
            end
        end
    end

    assign IRQN     = irqn;
    assign PVL_3_0  = pvl;
    assign PIL_3_0  = pil;
    assign PID_15_0 = pid;
    assign PIA_15_0 = pia;

endmodule

// File: tb/tb_cga_intr_level_sched.sv
// tb_cga_intr_level_sched
// Directed walk through the scheduler's handshake scenarios, followed by a
// randomized stretch. Every cycle is compared against a behavioural model of
// the scheduling rules. Define CGA_INTR_SCHED_WATCHDOG_EN to build the bench
// against the watchdog variant, which uses a short timeout.

module tb_cga_intr_level_sched;

`ifdef CGA_INTR_SCHED_WATCHDOG_EN
    localparam int TB_TIMEOUT = 4;
`endif

    logic        mclk;
    logic        reset;
    logic [15:0] ireq_n;
    logic [15:0] pie;
    logic [15:0] fidbo;
    logic        set_pid;
    logic        clr_pid;
    logic        intack;
    logic        lvl_done;
    logic        irqn;
    logic [3:0]  pvl;
    logic [3:0]  pil;
    logic [15:0] pid;
    logic [15:0] pia;
    logic        busy;
    logic        tmo;

    int checks;
    int failures;

    // Model of the scheduler, kept in terms of levels and handshake phase
    bit [15:0] m_pid;
    bit [15:0] m_pia;
    int        m_pil;
    int        m_pvl;
    bit        m_irqn;
    int        m_phase;   // 0 = nothing offered, 1 = offering, 2 = settle gap
    int        m_wait;
    bit        m_tmo;

`ifdef CGA_INTR_SCHED_WATCHDOG_EN
    cga_intr_level_sched #(.ACK_TIMEOUT(TB_TIMEOUT)) dut (
`else
    cga_intr_level_sched dut (
`endif
        .MCLK        (mclk),
        .RESET       (reset),
        .IREQ_15_0_N (ireq_n),
        .PIE_15_0    (pie),
        .FIDBO_15_0  (fidbo),
        .SETPID      (set_pid),
        .CLRPID      (clr_pid),
        .INTACK      (intack),
        .LVLDONE     (lvl_done),
        .IRQN        (irqn),
        .PVL_3_0     (pvl),
        .PIL_3_0     (pil),
        .PID_15_0    (pid),
        .PIA_15_0    (pia),
        .BUSY        (busy),
        .TMO         (tmo)
    );

    // Free-running master clock
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    function automatic int highest(input bit [15:0] v);
        int h;
        h = -1;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) h = i;
        end
        return h;
    endfunction

    task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ":IRQN"}, {15'd0, irqn}, {15'd0, m_irqn});
        checkValue({tag, ":PVL"},  {12'd0, pvl},  16'(m_pvl));
        checkValue({tag, ":PIL"},  {12'd0, pil},  16'(m_pil));
        checkValue({tag, ":PID"},  pid,           m_pid);
        checkValue({tag, ":PIA"},  pia,           m_pia);
        checkValue({tag, ":BUSY"}, {15'd0, busy}, {15'd0, m_phase != 0});
        checkValue({tag, ":TMO"},  {15'd0, tmo},  {15'd0, m_tmo});
    endtask

    // Compute the model's next state from the current inputs, clock once, then compare
    task automatic applyStimulus(input string tag);
        bit [15:0] p;
        bit [15:0] a;
        int        l;
        int        q;
        bit        valid;
        bit        acc;
        bit        expired;
        if (reset) begin
            m_pid = 16'h0000; m_pia = 16'h0001; m_pil = 0; m_pvl = 0;
            m_irqn = 1'b1; m_phase = 0; m_wait = 0; m_tmo = 1'b0;
        end else begin
            acc   = (m_phase == 1) && intack;
            q     = highest(m_pid & pie);
            valid = (q >= 0) && (q > m_pil);
            p = m_pid;
            if (acc) p[m_pvl] = 1'b0;
            if (clr_pid) p = p & ~fidbo;
            if (set_pid) p = p | fidbo;
            p = p | ~ireq_n;
            a = m_pia;
            l = m_pil;
            if (lvl_done && m_pil != 0) begin
                a[m_pil] = 1'b0;
                l = highest(a);
            end
            if (acc) begin
                a[m_pvl] = 1'b1;
                l = m_pvl;
            end
            expired = 1'b0;
`ifdef CGA_INTR_SCHED_WATCHDOG_EN
            expired = (m_wait == TB_TIMEOUT - 1);
`endif
            case (m_phase)
                0: begin
                    m_irqn = 1'b1;
                    if (valid) begin
                        m_pvl = q; m_phase = 1; m_wait = 0;
                    end
                end
                1: begin
                    if (acc) begin
                        m_phase = 2; m_irqn = 1'b1;
                    end else if (!valid) begin
                        m_phase = 0; m_irqn = 1'b1;
                    end else if (expired) begin
                        m_phase = 0; m_irqn = 1'b1; m_tmo = 1'b1;
                    end else begin
                        m_pvl = q; m_irqn = 1'b0; m_wait++;
                    end
                end
                default: begin
                    m_phase = 0; m_irqn = 1'b1;
                end
            endcase
            m_pid = p;
            m_pia = a;
            m_pil = l;
        end
        @(posedge mclk);
        #1;
        checkOutput(tag);
    endtask

    task automatic quietInputs();
        reset = 1'b0; ireq_n = 16'hFFFF; fidbo = 16'h0000;
        set_pid = 1'b0; clr_pid = 1'b0; intack = 1'b0; lvl_done = 1'b0;
    endtask

    // Directed scenarios, then randomized traffic, then reset during a handshake
    initial begin
        checks = 0;
        failures = 0;
        quietInputs();
        pie = 16'hFFFF;
        reset = 1'b1;
        applyStimulus("reset0");
        applyStimulus("reset1");
        checkValue("reset_pia", pia, 16'h0001);
        checkValue("reset_irqn", {15'd0, irqn}, 16'h0001);
        reset = 1'b0;

        // Level 10 request, offer and acknowledge
        ireq_n = ~16'h0400;
        applyStimulus("req10_pend");
        checkValue("req10_pid", pid, 16'h0400);
        ireq_n = 16'hFFFF;
        applyStimulus("req10_latch");
        checkValue("req10_pvl", {12'd0, pvl}, 16'd10);
        checkValue("req10_irqn_still_high", {15'd0, irqn}, 16'd1);
        applyStimulus("req10_irqn");
        checkValue("req10_irqn_low", {15'd0, irqn}, 16'd0);
        intack = 1'b1;
        applyStimulus("req10_ack");
        checkValue("ack10_pil", {12'd0, pil}, 16'd10);
        checkValue("ack10_pia", pia, 16'h0401);
        checkValue("ack10_pid", pid, 16'h0000);
        checkValue("ack10_settle_irqn", {15'd0, irqn}, 16'd1);
        intack = 1'b0;
        applyStimulus("settle_exit");

        // Nesting: level 12 preempts, level 11 waits, LVLDONE returns to 10
        ireq_n = ~16'h1000;
        applyStimulus("req12_pend");
        ireq_n = 16'hFFFF;
        applyStimulus("req12_latch");
        applyStimulus("req12_irqn");
        intack = 1'b1;
        applyStimulus("req12_ack");
        checkValue("ack12_pil", {12'd0, pil}, 16'd12);
        checkValue("ack12_pia", pia, 16'h1401);
        intack = 1'b0;
        applyStimulus("req12_settle");
        ireq_n = ~16'h0800;
        applyStimulus("req11_pend");
        ireq_n = 16'hFFFF;
        applyStimulus("req11_blocked0");
        applyStimulus("req11_blocked1");
        checkValue("req11_blocked_irqn", {15'd0, irqn}, 16'd1);
        lvl_done = 1'b1;
        applyStimulus("done12");
        checkValue("done12_pil", {12'd0, pil}, 16'd10);
        checkValue("done12_pia", pia, 16'h0401);
        lvl_done = 1'b0;
        applyStimulus("req11_latch");
        checkValue("req11_pvl", {12'd0, pvl}, 16'd11);
        applyStimulus("req11_irqn");

        // Re-targeting to level 13 via a software set while offering 11
        set_pid = 1'b1; fidbo = 16'h2000;
        applyStimulus("setpid13");
        quietInputs();
        applyStimulus("retarget13");
        checkValue("retarget_pvl", {12'd0, pvl}, 16'd13);
        checkValue("retarget_irqn", {15'd0, irqn}, 16'd0);
        intack = 1'b1;
        applyStimulus("ack13");
        checkValue("ack13_pil", {12'd0, pil}, 16'd13);
        intack = 1'b0;
        applyStimulus("ack13_settle");
        lvl_done = 1'b1;
        applyStimulus("done13");
        lvl_done = 1'b0;
        applyStimulus("reoffer11_latch");
        applyStimulus("reoffer11_irqn");

        // Withdrawal when the offered level loses its enable
        pie = 16'hF7FF;
        applyStimulus("withdraw11");
        checkValue("withdraw_irqn", {15'd0, irqn}, 16'd1);
        checkValue("withdraw_busy", {15'd0, busy}, 16'd0);
        checkValue("withdraw_pid11", {15'd0, pid[11]}, 16'd1);
        clr_pid = 1'b1; fidbo = 16'h0800;
        applyStimulus("clear11");
        quietInputs();
        pie = 16'hFFFF;
        applyStimulus("pie_restore");

        // SETPID wins over CLRPID; LVLDONE at level 0 does nothing
        set_pid = 1'b1; clr_pid = 1'b1; fidbo = 16'h0100;
        applyStimulus("set_and_clr");
        checkValue("set_wins_pid8", {15'd0, pid[8]}, 16'd1);
        quietInputs();
        lvl_done = 1'b1;
        applyStimulus("done10");
        lvl_done = 1'b0;
        applyStimulus("req8_latch");
        applyStimulus("req8_irqn");
        intack = 1'b1;
        applyStimulus("ack8");
        intack = 1'b0;
        applyStimulus("ack8_settle");
        lvl_done = 1'b1;
        applyStimulus("done8");
        applyStimulus("done_at_zero");
        checkValue("done_zero_pia", pia, 16'h0001);
        checkValue("done_zero_pil", {12'd0, pil}, 16'd0);
        lvl_done = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            quietInputs();
            if ($urandom_range(0, 5) == 0) ireq_n = ~(16'h0001 << $urandom_range(0, 15));
            pie = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'hFFFF;
            fidbo = 16'($urandom);
            set_pid = ($urandom_range(0, 15) == 0);
            clr_pid = ($urandom_range(0, 15) == 0);
            intack = (!m_irqn && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
            lvl_done = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 149) == 0);
            applyStimulus("random");
        end

        // Reset while an offer is outstanding and INTACK is high
        quietInputs();
        pie = 16'hFFFF;
        ireq_n = ~16'h0020;
        applyStimulus("mid_pend");
        ireq_n = 16'hFFFF;
        applyStimulus("mid_latch");
        applyStimulus("mid_irqn");
        reset = 1'b1; intack = 1'b1;
        applyStimulus("mid_reset");
        checkValue("mid_reset_pil", {12'd0, pil}, 16'd0);
        checkValue("mid_reset_pid", pid, 16'h0000);
        checkValue("mid_reset_busy", {15'd0, busy}, 16'd0);
        quietInputs();
        applyStimulus("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cga_intr_level_sched.md
Name: cga_intr_level_sched

Overview:
- Program-level interrupt scheduler for the CGA interrupt path.
- Collects the 16 active-low level requests (IREQ_15_0_N) into a sticky pending register (PID) and qualifies them with the enable mask (PIE).
- Arbitrates the highest pending level above the current program level and presents it to microcode with an IRQN/INTACK handshake.
- Tracks active (in-service) levels so nested interrupts return to the correct level.

Parameters:
- ACK_TIMEOUT, 255: cycles in REQ without INTACK before withdrawal. Used only with CGA_INTR_SCHED_WATCHDOG_EN.

Ports:
- MCLK  in  1  master clock; all state changes on the rising edge
- RESET  in  1  synchronous, active-high reset
- IREQ_15_0_N  in  16  level requests, active low; bit n = level n
- PIE_15_0  in  16  level enable mask, 1 = enabled
- FIDBO_15_0  in  16  data bus, used for PID software writes
- SETPID  in  1  pulse: PID |= FIDBO_15_0
- CLRPID  in  1  pulse: PID &= ~FIDBO_15_0
- INTACK  in  1  microcode accepts the offered level; meaningful only in REQ
- LVLDONE  in  1  pulse: current level finished (return from interrupt)
- IRQN  out  1  interrupt request to microcode, active low
- PVL_3_0  out  4  offered (pending vector) level
- PIL_3_0  out  4  current program level
- PID_15_0  out  16  pending register
- PIA_15_0  out  16  active-level register; bit 0 is always 1
- BUSY  out  1  high in REQ or SETTLE
- TMO  out  1  sticky ack-timeout flag (watchdog builds only, otherwise 0)

Behaviour:
- Reset values (RESET high at a clock edge): PID=0, PIA=16'h0001, PIL=0, PVL=0, IRQN=1, BUSY=0, TMO=0, state=IDLE.
- PID update, applied in this order each cycle:
  1. clear the INTACK-accepted bit;
  2. apply CLRPID;
  3. apply SETPID;
  4. OR in ~IREQ_15_0_N.
  A later step wins for the same bit, so a still-asserted request re-pends in the same cycle.
- Candidate: CAND = index of the highest set bit of (PID & PIE). CAND is valid when that AND is non-zero and CAND > PIL. Level 0 can therefore never be offered.
- States:
  - IDLE: IRQN=1. If the candidate is valid, PVL<=CAND and go to REQ. IRQN falls on the cycle after entry to REQ: 1 cycle latency from PID set to PVL latch, and IRQN low on the following edge.
  - REQ: IRQN=0.
    - Every cycle without INTACK, re-evaluate: a higher valid CAND updates PVL (re-targeting); IRQN stays low.
    - If the candidate is no longer valid (PIE cleared, CLRPID, or PIL raised), withdraw: IRQN=1, go to IDLE.
    - On INTACK: PIL<=PVL, PIA[PVL]<=1, clear PID[PVL], go to SETTLE. The accepted level is the PVL visible on that cycle; re-targeting does not apply on an INTACK cycle.
  - SETTLE: IRQN=1 for exactly one cycle, then IDLE. Guarantees a minimum high pulse between requests.
- LVLDONE, honoured in any state:
  - If PIL!=0, clear PIA[PIL] and set PIL <= index of the highest remaining set bit of PIA.
  - If PIL=0, no effect.
  - Simultaneous with INTACK: the old PIL is cleared first, then the INTACK update is applied, so the final PIL=PVL.
- INTACK outside REQ is ignored. SETPID and CLRPID in the same cycle: SETPID wins for common bits.
- RESET mid-handshake: returns to IDLE with all reset values. Outstanding INTACK in the reset cycle is ignored.
- IREQ_15_0_N is sampled unsynchronised; the sources are synchronous to MCLK.

Optional Feature:
- Macro: CGA_INTR_SCHED_WATCHDOG_EN.
- Defined:
  - An 8-bit counter (width fixed by ACK_TIMEOUT<=255) clears on REQ entry and increments each REQ cycle without INTACK.
  - When it reaches ACK_TIMEOUT: withdraw to IDLE, IRQN=1, set TMO. PID is left intact, so the request re-arbitrates next cycle.
  - TMO is cleared only by RESET.
- Not defined: no counter; REQ waits indefinitely; TMO is tied to 0.

Test Plan:
- Reset, PIE=16'hFFFF, drive IREQ bit 10 low one cycle -> PID=16'h0400; PVL=10 next edge; IRQN low the edge after; INTACK -> PIL=10, PIA=16'h0401, PID=0, IRQN high one cycle (SETTLE).
- PIL=10 active, assert IREQ bit 12 -> offered and acked, PIL=12, PIA=16'h1401. Then IREQ bit 11 -> no IRQN. LVLDONE -> PIL=10, PIA=16'h0401; then level 11 is offered.
- In REQ with PVL=11 and no INTACK, set PID bit 13 via SETPID with FIDBO=16'h2000 -> PVL=13, IRQN stays low; INTACK -> PIL=13.
- In REQ with PVL=11, clear PIE bit 11 -> IRQN high next edge, state IDLE, PID bit 11 still set.
- SETPID and CLRPID together with FIDBO=16'h0100 -> PID bit 8 set. LVLDONE at PIL=0 -> PIA stays 16'h0001.
- Watchdog build, ACK_TIMEOUT=4: request level 5 with no INTACK -> IRQN high after 4 REQ cycles, TMO=1; re-request follows (SETTLE is not used on withdrawal, so re-offer starts the cycle after IDLE).
